// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the loader's bus signals so that the loader and its surroundings
// share one bundle.
//   slave  modport : the loader itself (consumes load/rx/fetch inputs,
//                    drives the instruction-memory port and status)
//   master modport : debug unit / UART / PC side plus memory consumer
// Signals:
//   start_load   - single-cycle request to begin a program load
//   rx_valid     - single-cycle strobe, rx_data holds a received byte
//   rx_data      - received byte
//   fetch_addr   - instruction address from the PC stage
//   mem_wr_en    - instruction memory write strobe
//   mem_addr     - instruction memory address (loader or fetch_addr)
//   mem_wr_data  - assembled instruction word
//   cpu_stall    - holds PC and pipeline during a load
//   load_done    - a load has completed since the last start_load/reset
//   word_count   - words written in the current or last load
//   overflow_err - sticky, program exceeded memory depth
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start_load;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [31:0]       fetch_addr;
    logic              mem_wr_en;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wr_data;
    logic              cpu_stall;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic              overflow_err;

    modport slave (
        input  start_load, rx_valid, rx_data, fetch_addr,
        output mem_wr_en, mem_addr, mem_wr_data, cpu_stall,
               load_done, word_count, overflow_err
    );

    modport master (
        output start_load, rx_valid, rx_data, fetch_addr,
        input  mem_wr_en, mem_addr, mem_wr_data, cpu_stall,
               load_done, word_count, overflow_err
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads a program received byte-by-byte (big-endian, 4 bytes per word) into
// the instruction memory. While a load is in progress the CPU is stalled and
// the memory address comes from the loader; otherwise the memory address
// follows the PC's fetch_addr. A word equal to HALT_WORD ends the load
// without being written; a program longer than the memory sets a sticky
// overflow_err and ends the load.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - imem_loader_if.slave (load request, rx bytes, fetch address,
//          memory write port, stall and status outputs)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Memory depth expressed in word_count's width (2^ADDR_W).
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t          state_q, state_d;
    logic [1:0]      byte_idx_q;
    logic [31:0]     asm_q;        // byte shift register
    logic [31:0]     wr_data_q;    // last complete word, held for the write
    logic [ADDR_W:0] word_count_q;
    logic            overflow_q;

    logic            loading;
    logic            accept;
    logic            word_end;
    logic            at_limit;
    logic            is_halt;
    logic            load_req;
    logic [31:0]     word_next;

    assign loading   = (state_q == ASSEMBLE) || (state_q == WRITE);
    assign load_req  = bus.start_load && !loading;
    assign accept    = bus.rx_valid && loading;
    assign word_next = {asm_q[23:0], bus.rx_data};
    // The 4th byte can only arrive in ASSEMBLE: WRITE always follows a
    // wrap of byte_idx to 0.
    assign word_end  = accept && (byte_idx_q == 2'd3);
    assign at_limit  = (word_count_q == DEPTH);
    assign is_halt   = (word_next == HALT_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_load) begin
                    state_d = ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                if (word_end) begin
                    if (is_halt || at_limit) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                state_d = ASSEMBLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_q   <= 2'd0;
            asm_q        <= 32'd0;
            wr_data_q    <= 32'd0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else if (load_req) begin
            byte_idx_q   <= 2'd0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (accept) begin
                asm_q      <= word_next;
                byte_idx_q <= byte_idx_q + 2'd1;
            end
            if (word_end) begin
                wr_data_q <= word_next;
                if (!is_halt && at_limit) begin
                    overflow_q <= 1'b1;
                end
            end
            // WRITE is only entered below the limit; the guard keeps the
            // counter from ever wrapping.
            if (state_q == WRITE && !at_limit) begin
                word_count_q <= word_count_q + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    assign bus.mem_wr_en    = (state_q == WRITE);
    assign bus.mem_addr     = loading
                            ? {{(32-ADDR_W){1'b0}}, word_count_q[ADDR_W-1:0]}
                            : bus.fetch_addr;
    assign bus.mem_wr_data  = wr_data_q;
    assign bus.cpu_stall    = loading;
    assign bus.load_done    = (state_q == DONE);
    assign bus.word_count   = word_count_q;
    assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Randomized bench for imem_loader. Stimulus tasks feed program words and,
// from a word-level model of the loader (halt / overflow / write rules),
// push the expected memory writes into a queue. A monitor pops that queue
// on every write strobe and compares address and data.
// ---------------------------------------------------------------------------
module tb_imem_loader;
    localparam int          AW    = 5;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .HALT_WORD(HALT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t         exp_q[$];
    logic [31:0] prog[$];
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         bus.mem_addr, bus.mem_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_addr, e.addr);
                chk("wr_data", bus.mem_wr_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        repeat ($urandom_range(gapmax, 0)) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8], gapmax);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == HALT) w = 32'h1234_5678;
        return w;
    endfunction

    task automatic wait_done();
        int k = 0;
        while (bus.load_done !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        chk("load_done_timeout", {31'd0, bus.load_done}, 32'd1);
    endtask

    // Word-level model: a load writes consecutive addresses from 0 until a
    // halt word, or until a word arrives with the memory already full.
    task automatic run_load(input int gapmax, input logic [31:0] fa);
        int  cnt = 0;
        bit  ovf = 1'b0;
        bus.fetch_addr = fa;
        pulse_start();
        chk("stall_in_load", {31'd0, bus.cpu_stall}, 32'd1);
        foreach (prog[i]) begin
            bit last = 1'b0;
            if (prog[i] == HALT) begin
                last = 1'b1;
            end else if (cnt == DEPTH) begin
                ovf  = 1'b1;
                last = 1'b1;
            end else begin
                exp_q.push_back('{addr: cnt, data: prog[i]});
                cnt++;
            end
            send_word(prog[i], gapmax);
            if (last) break;
        end
        wait_done();
        tick();
        chk("pending_writes", exp_q.size(), 32'd0);
        chk("word_count", {26'd0, bus.word_count}, cnt);
        chk("overflow_err", {31'd0, bus.overflow_err}, {31'd0, ovf});
        chk("stall_done", {31'd0, bus.cpu_stall}, 32'd0);
        chk("addr_follow_done", bus.mem_addr, fa);
    endtask

    initial begin
        logic [31:0] w;
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.start_load = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.fetch_addr = 32'd7;
        repeat (3) tick();
        chk("rst_mem_addr", bus.mem_addr, 32'd7);
        chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("rst_load_done", {31'd0, bus.load_done}, 32'd0);
        chk("rst_word_count", {26'd0, bus.word_count}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_mem_addr", bus.mem_addr, 32'd7);

        // Bytes while idle are ignored.
        send_word(32'hDEAD_BEEF, 0);
        chk("idle_no_count", {26'd0, bus.word_count}, 32'd0);

        // Known program: one word then halt.
        prog = '{32'h0022_1820, HALT};
        run_load(2, 32'h0000_0040);

        // Back-to-back bytes, including one during each WRITE cycle.
        prog = '{rand_word(), rand_word(), rand_word(), HALT};
        run_load(0, 32'h0000_0100);

        // Overflow: 33 non-halt words.
        prog.delete();
        for (int i = 0; i < DEPTH + 1; i++) prog.push_back(rand_word());
        run_load(1, 32'h0000_0200);

        // Random programs, including a near-halt word.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(6, 0);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(rand_word());
            if (t == 1) prog.push_back(32'hFFFF_FFFE);
            prog.push_back(HALT);
            run_load(3, $urandom());
        end

        // start_load during ASSEMBLE is ignored.
        bus.fetch_addr = 32'h0000_0300;
        pulse_start();
        w = rand_word();
        exp_q.push_back('{addr: 0, data: w});
        send_word(w, 1);
        w = rand_word();
        exp_q.push_back('{addr: 1, data: w});
        send_byte(w[31:24], 1);
        send_byte(w[23:16], 1);
        pulse_start();
        chk("ignored_start_count", {26'd0, bus.word_count}, 32'd1);
        chk("ignored_start_stall", {31'd0, bus.cpu_stall}, 32'd1);
        send_byte(w[15:8], 1);
        send_byte(w[7:0], 1);
        send_word(HALT, 1);
        wait_done();
        chk("ignored_start_pending", exp_q.size(), 32'd0);
        chk("ignored_start_wc", {26'd0, bus.word_count}, 32'd2);

        // Reset in the middle of a word aborts with no write.
        bus.fetch_addr = 32'h0000_0444;
        pulse_start();
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0000_0444);
        chk("abort_wc", {26'd0, bus.word_count}, 32'd0);
        chk("abort_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        tick();
        rst = 1'b0;
        tick();
        prog = '{32'hCAFE_0001, HALT};
        run_load(1, 32'h0000_0444);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
